// File: rtl/loom_dpi_checker_pkg.sv
// Shared types, op sequencing, reference model and in-simulator host for the Loom DPI self-check engine.
package loom_dpi_checker_pkg;

  typedef enum logic [2:0] {
    StIdle, StLoadA, StCall, StCheck, StNext, StReport, StDone
  } state_e;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpXor = 2'd2
  } op_e;

  // An empty enable mask behaves as ADD-only.
  function automatic logic [2:0] op_mask(logic [2:0] en);
    return (en == 3'b000) ? 3'b001 : en;
  endfunction

  function automatic op_e first_op(logic [2:0] en);
    logic [2:0] m;
    m = op_mask(en);
    return m[0] ? OpAdd : (m[1] ? OpSub : OpXor);
  endfunction

  function automatic op_e next_op(op_e op, logic [2:0] en);
    logic [2:0] m;
    op_e        r;
    m = op_mask(en);
    case (op)
      OpAdd:   r = m[1] ? OpSub : (m[2] ? OpXor : OpAdd);
      OpSub:   r = m[2] ? OpXor : (m[0] ? OpAdd : OpSub);
      default: r = m[0] ? OpAdd : (m[1] ? OpSub : OpXor);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_model(op_e op, logic [31:0] a, logic [31:0] b, int width);
    logic [31:0] r;
    logic [31:0] mask;
    case (op)
      OpAdd:   r = a + b;
      OpSub:   r = a - b;
      default: r = a ^ b;
    endcase
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return r & mask;
  endfunction

  // Loopback host: a correct ALU that can be told to corrupt one (op, a, b) call,
  // and a report sink that remembers the last report.
  bit dpi_corrupt_en   = 1'b0;
  int dpi_corrupt_op   = 0;
  int dpi_corrupt_a    = 0;
  int dpi_corrupt_b    = 0;
  int dpi_report_calls = 0;
  int dpi_report_pass  = 0;
  int dpi_report_fail  = 0;

  function automatic int dpi_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      default: r = a ^ b;
    endcase
    if (dpi_corrupt_en && op == dpi_corrupt_op && a == dpi_corrupt_a && b == dpi_corrupt_b)
      r = r + 1;
    return r;
  endfunction

  function automatic int dpi_report_result(input int passed, input int failed);
    dpi_report_calls = dpi_report_calls + 1;
    dpi_report_pass  = passed;
    dpi_report_fail  = failed;
    return 0;
  endfunction

endpackage

// File: rtl/loom_lfsr.sv
// Galois LFSR: shifts right, XORing TAPS in when the bit shifted out is set.
module loom_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/loom_dpi_checker.sv
// DPI self-check engine: LFSR operands -> dpi_alu -> local reference compare -> report.
// LOOM_DPI_CHECKER_FINISH_EN: end the simulation on the first StDone cycle.
module loom_dpi_checker
  import loom_dpi_checker_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int                N_ITER    = 8,
  parameter logic [2:0]        OP_EN     = 3'b111,
  localparam int               CNT_W     = $clog2(N_ITER + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] n_pass_o,
  output logic [CNT_W-1:0] n_fail_o,
  output logic [CNT_W-1:0] first_fail_o,
  output logic             err_o
);

  localparam op_e FIRST_OP = first_op(OP_EN);

  state_e            state_q;
  op_e               op_q;
  logic [CNT_W-1:0]  iter_q, n_pass_q, n_fail_q, first_fail_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic              busy_q, done_q, err_q;

  logic [LFSR_W-1:0] lfsr;
  logic [DATA_W-1:0] opnd;
  logic              step, last_iter, ref_ok;
  logic [31:0]       ref_w;

  loom_lfsr #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .step_i  (step),
    .value_o (lfsr)
  );

  assign opnd      = DATA_W'(lfsr);
  assign last_iter = (iter_q == CNT_W'(N_ITER - 1));

  // The LFSR advances on every operand draw: LoadA, Call, and a non-final Next.
  always_comb begin
    step = 1'b0;
    case (state_q)
      StLoadA, StCall: step = 1'b1;
      StNext:          step = !last_iter;
      default:         step = 1'b0;
    endcase
  end

  always_comb begin
    ref_w  = ref_model(op_q, 32'(a_q), 32'(b_q), DATA_W);
    ref_ok = (ref_w == 32'(result_q));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= FIRST_OP;
      iter_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      n_pass_q     <= '0;
      n_fail_q     <= '0;
      first_fail_q <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        // A rerun restarts the op rotation but keeps the LFSR where it is.
        StIdle, StDone: begin
          if (start_i) begin
            state_q      <= StLoadA;
            op_q         <= FIRST_OP;
            iter_q       <= '0;
            n_pass_q     <= '0;
            n_fail_q     <= '0;
            first_fail_q <= '1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
          end
`ifdef LOOM_DPI_CHECKER_FINISH_EN
          if (state_q == StDone) $finish;
`endif
        end
        StLoadA: begin
          a_q     <= opnd;
          state_q <= StCall;
        end
        StCall: begin
          b_q      <= opnd;
          result_q <= DATA_W'(dpi_alu(int'(op_q), int'(32'(a_q)), int'(32'(opnd))));
          state_q  <= StCheck;
        end
        StCheck: begin
          if (ref_ok) begin
            n_pass_q <= n_pass_q + 1'b1;
          end else begin
            n_fail_q <= n_fail_q + 1'b1;
            if (first_fail_q == '1) first_fail_q <= iter_q;
          end
          state_q <= StNext;
        end
        StNext: begin
          if (last_iter) begin
            state_q <= StReport;
          end else begin
            iter_q  <= iter_q + 1'b1;
            op_q    <= next_op(op_q, OP_EN);
            a_q     <= opnd;
            state_q <= StCall;
          end
        end
        StReport: begin
          void'(dpi_report_result(int'(n_pass_q), int'(n_fail_q)));
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= (n_fail_q != '0);
          state_q <= StDone;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign n_pass_o     = n_pass_q;
  assign n_fail_o     = n_fail_q;
  assign first_fail_o = first_fail_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_loom_dpi_checker.sv
// Randomized check of loom_dpi_checker (DATA_W=16, all ops) against an operand/result model.
module tb_loom_dpi_checker;
  import loom_dpi_checker_pkg::*;

  localparam int          DW   = 16;
  localparam int          NI   = 8;
  localparam int          CW   = $clog2(NI + 1);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          start_i = 1'b0;
  logic          busy_o, done_o, err_o;
  logic [CW-1:0] n_pass_o, n_fail_o, first_fail_o;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;

  loom_dpi_checker #(.DATA_W(DW), .N_ITER(NI)) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .n_pass_o     (n_pass_o),
    .n_fail_o     (n_fail_o),
    .first_fail_o (first_fail_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lstep(logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0);
  endfunction

  function automatic logic [15:0] m_alu(int op, logic [15:0] a, logic [15:0] b);
    case (op)
      0:       return a + b;
      1:       return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // One full run; cidx < 0 means a clean host, otherwise call cidx is corrupted.
  // poke_cyc > 0 raises start_i for one cycle mid-run.
  task automatic run_once(input int cidx, input int poke_cyc, input bit hold);
    logic [15:0] a [NI];
    logic [15:0] b [NI];
    logic [15:0] r;
    int          cyc, k, rep0, nfail, low;
    for (int i = 0; i < NI; i++) begin
      a[i] = m_lfsr; m_lfsr = lstep(m_lfsr);
      b[i] = m_lfsr; m_lfsr = lstep(m_lfsr);
    end
    nfail = (cidx >= 0) ? 1 : 0;
    loom_dpi_checker_pkg::dpi_corrupt_en = (cidx >= 0);
    if (cidx >= 0) begin
      loom_dpi_checker_pkg::dpi_corrupt_op = cidx % 3;
      loom_dpi_checker_pkg::dpi_corrupt_a  = int'({16'h0, a[cidx]});
      loom_dpi_checker_pkg::dpi_corrupt_b  = int'({16'h0, b[cidx]});
    end
    rep0 = loom_dpi_checker_pkg::dpi_report_calls;

    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 200) begin
      start_i = (cyc == poke_cyc);
      @(negedge clk_i);
      cyc++;
      if (cyc >= 3 && cyc <= 3 * NI && (cyc % 3) == 0) begin
        k = cyc / 3 - 1;
        r = m_alu(k % 3, a[k], b[k]);
        if (k == cidx) r = r + 16'd1;
        chk("result", 32'(u_dut.result_q), 32'(r));
      end
    end
    start_i = 1'b0;

    chk("latency",    cyc,                  3 + 3 * NI);
    chk("n_pass",     32'(n_pass_o),        NI - nfail);
    chk("n_fail",     32'(n_fail_o),        nfail);
    chk("first_fail", 32'(first_fail_o),    (cidx >= 0) ? cidx : (1 << CW) - 1);
    chk("err",        32'(err_o),           32'(nfail != 0));
    chk("busy_done",  32'(busy_o),          0);
    chk("rep_calls",  loom_dpi_checker_pkg::dpi_report_calls, rep0 + 1);
    chk("rep_pass",   loom_dpi_checker_pkg::dpi_report_pass,   NI - nfail);
    chk("rep_fail",   loom_dpi_checker_pkg::dpi_report_fail,   nfail);

    if (hold) begin
      low = 0;
      repeat (100) begin
        @(negedge clk_i);
        if (!done_o) low++;
      end
      chk("done_hold",      low, 0);
      chk("rep_once",       loom_dpi_checker_pkg::dpi_report_calls, rep0 + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rep0;
    m_lfsr = SEED;
    repeat (2) @(negedge clk_i);
    chk("rst_busy",  32'(busy_o),       0);
    chk("rst_done",  32'(done_o),       0);
    chk("rst_pass",  32'(n_pass_o),     0);
    chk("rst_fail",  32'(n_fail_o),     0);
    chk("rst_ff",    32'(first_fail_o), (1 << CW) - 1);
    chk("rst_err",   32'(err_o),        0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("idle_busy", 32'(busy_o), 0);

    run_once(-1, 0, 1'b1);
    run_once(3, 0, 1'b0);
    run_once(-1, 6, 1'b0);
    for (int i = 0; i < 6; i++)
      run_once(int'($urandom_range(8, 0)) - 1, int'($urandom_range(20, 0)), 1'b0);

    // Reset during StCall of call 4: no report, outputs back to reset values.
    loom_dpi_checker_pkg::dpi_corrupt_en = 1'b0;
    rep0 = loom_dpi_checker_pkg::dpi_report_calls;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    repeat (13) @(negedge clk_i);
    chk("pre_rst_busy", 32'(busy_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_o),       0);
    chk("mid_rst_done", 32'(done_o),       0);
    chk("mid_rst_pass", 32'(n_pass_o),     0);
    chk("mid_rst_ff",   32'(first_fail_o), (1 << CW) - 1);
    repeat (3) @(negedge clk_i);
    chk("mid_rst_norep", loom_dpi_checker_pkg::dpi_report_calls, rep0);
    rst_ni = 1'b1;
    m_lfsr = SEED;
    run_once(int'($urandom_range(7, 0)), 0, 1'b0);
    run_once(-1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
